or1200_vlx_byte_stuffer: RTL and testbench
==========================================

Name: or1200_vlx_byte_stuffer

Overview:
Downstream stage of the VLX bit-packing datapath. Accepts completed output bytes from the bit packer, buffers them in a small FIFO, and writes them one at a time to data memory through the store handshake (store_byte_o / ack_i). When stuffing is compiled in, it inserts a 0x00 byte after every 0xFF (JPEG marker stuffing). Raises busy_o while any byte is buffered or in flight, so the VLX top can stall the CPU until the stream has drained.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
byte_valid_i  in  1  upstream presents byte_i this cycle
byte_i  in  8  packed output byte
byte_ready_o  out  1  FIFO can accept; push = byte_valid_i & byte_ready_o
set_init_addr_i  in  1  load the destination address
addr_i  in  32  address loaded when set_init_addr_i is high
ack_i  in  1  memory acknowledge for the current byte store
store_byte_o  out  1  byte store request, held until ack_i
vlx_addr_o  out  32  byte address of the current store
dat_o  out  32  store data, byte replicated on all four lanes
busy_o  out  1  FIFO not empty, or state not IDLE
stuff_cnt_o  out  16  number of 0x00 bytes inserted since reset

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset values: FIFO pointers and count = 0; state = IDLE; vlx_addr_o = 0; store_byte_o = 0; dat_o = 0; stuff_cnt_o = 0; busy_o = 0; byte_ready_o = 1 in the first cycle after reset.
- FIFO:
  - Circular buffer with write pointer, read pointer and a count of AW+1 bits.
  - byte_ready_o = (count != DEPTH). When full, the FIFO does not accept a push, even if a pop happens in the same cycle.
  - Push and pop in the same cycle: count is unchanged.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, STORE, STUFF):
  - IDLE: store_byte_o = 0. If count != 0, go to STORE on the next cycle.
  - STORE: store_byte_o = 1; dat_o = {head, head, head, head}, where head is the FIFO entry at the read pointer.
    - On ack_i: pop the FIFO and increment vlx_addr_o by 1.
    - Next state: STUFF if head == 0xFF (and stuffing is enabled); else STORE if count after the pop is != 0; else IDLE.
  - STUFF: store_byte_o = 1; dat_o = 0x00000000.
    - On ack_i: increment vlx_addr_o by 1 and stuff_cnt_o by 1, saturating at 0xFFFF.
    - Next state: STORE if count != 0, else IDLE.
  - Without ack_i, STORE and STUFF hold, and store_byte_o, dat_o and vlx_addr_o stay stable.
  - Minimum latency from push to store_byte_o is 2 cycles.
- Addressing:
  - vlx_addr_o is a 32-bit register and wraps from 0xFFFFFFFF to 0.
  - set_init_addr_i loads addr_i on the next edge. If an ack arrives in the same cycle, the load wins and no increment happens.
  - A load mid-operation does not abort the current store; the following stores continue from the new address.
- busy_o = (count != 0) | (state != IDLE).
- Reset during a store: everything returns to the reset values in one cycle, and buffered bytes are discarded.
- ack_i seen in IDLE is ignored.

Optional Feature:
VLX_BYTE_STUFF_EN.
- Defined: 0xFF triggers the STUFF state as described above.
- Undefined: the STUFF state is unreachable, so 0xFF is stored like any other byte. stuff_cnt_o is tied to 0.

Test Plan:
- Reset, then load addr 0x1000 and push 0x12, 0x34 with ack_i one cycle after each request → stores 0x12 at 0x1000 and 0x34 at 0x1001; busy_o falls afterwards; final vlx_addr_o = 0x1002.
- With stuffing enabled, push 0xFF then 0x00 → store sequence 0xFF @A, 0x00 @A+1, 0x00 @A+2; stuff_cnt_o = 1.
- Hold ack_i low and push 5 bytes with DEPTH = 4 → byte_ready_o drops after the 4th accept; the 5th byte is held upstream, then accepted after the first ack; order is preserved with no loss or duplication.
- Same cycle: set_init_addr_i with addr_i = 0x2000, plus ack_i in STORE → vlx_addr_o = 0x2000 (no +1); the next byte is stored at 0x2000.
- Assert rst_i while in STUFF with 3 bytes buffered → the next cycle shows state IDLE, store_byte_o = 0, busy_o = 0, byte_ready_o = 1, vlx_addr_o = 0.
- Build without the stuffing macro and push 0xFF, 0xFF → exactly two stores (0xFF, 0xFF) at A and A+1; stuff_cnt_o stays 0.

Source files
------------

// File: rtl/or1200_vlx_byte_stuffer.sv
// ============================================================================
// Module   : or1200_vlx_byte_stuffer
// Purpose  : Buffers packed VLX output bytes and stores them to data memory
//            one at a time, optionally inserting 0x00 after every 0xFF.
//            Optional stuffing enabled by defining VLX_BYTE_STUFF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module or1200_vlx_byte_stuffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  input  logic        set_init_addr_i,
  input  logic [31:0] addr_i,
  input  logic        ack_i,
  output logic        store_byte_o,
  output logic [31:0] vlx_addr_o,
  output logic [31:0] dat_o,
  output logic        busy_o,
  output logic [15:0] stuff_cnt_o
);

`ifdef VLX_BYTE_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [31:0]   vlx_addr;
  logic          push, pop;
  logic [7:0]    head;

  assign head         = mem[rd_ptr];
  assign byte_ready_o = (count != FULL);
  assign push         = byte_valid_i & byte_ready_o;
  assign pop          = (state == STORE) & ack_i;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage is not reset; entries are only ever read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      vlx_addr <= 32'h0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      state <= state_next;
      // An address load takes priority over the post-ack increment.
      if (set_init_addr_i)
        vlx_addr <= addr_i;
      else if (ack_i && state != IDLE)
        vlx_addr <= vlx_addr + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0) state_next = STORE;
      end
      STORE: begin
        if (ack_i) begin
          if (STUFF_EN && head == 8'hFF)
            state_next = STUFF;
          else if (count_next != '0)
            state_next = STORE;
          else
            state_next = IDLE;
        end
      end
      STUFF: begin
        if (ack_i) state_next = (count != '0) ? STORE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign store_byte_o = (state != IDLE);
  assign dat_o        = (state == STORE) ? {4{head}} : 32'h0;
  assign vlx_addr_o   = vlx_addr;
  assign busy_o       = (count != '0) | (state != IDLE);

`ifdef VLX_BYTE_STUFF_EN
  logic [15:0] stuff_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stuff_cnt <= 16'h0;
    else if (state == STUFF && ack_i && stuff_cnt != 16'hFFFF)
      stuff_cnt <= stuff_cnt + 16'd1;
  end

  assign stuff_cnt_o = stuff_cnt;
`else
  assign stuff_cnt_o = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_or1200_vlx_byte_stuffer.sv
// ============================================================================
// Module   : tb_or1200_vlx_byte_stuffer
// Purpose  : Self-checking bench; the reference is the expected store stream
//            (bytes plus inserted zeros) with a tracked destination address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or1200_vlx_byte_stuffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

`ifdef VLX_BYTE_STUFF_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_ready_o;
  logic        set_init_addr_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic        ack_i = 1'b0;
  logic        store_byte_o;
  logic [31:0] vlx_addr_o;
  logic [31:0] dat_o;
  logic        busy_o;
  logic [15:0] stuff_cnt_o;

  always #5 clk_i = ~clk_i;

  or1200_vlx_byte_stuffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .byte_valid_i    (byte_valid_i),
    .byte_i          (byte_i),
    .byte_ready_o    (byte_ready_o),
    .set_init_addr_i (set_init_addr_i),
    .addr_i          (addr_i),
    .ack_i           (ack_i),
    .store_byte_o    (store_byte_o),
    .vlx_addr_o      (vlx_addr_o),
    .dat_o           (dat_o),
    .busy_o          (busy_o),
    .stuff_cnt_o     (stuff_cnt_o)
  );

  typedef struct {
    logic [7:0] d;
    bit         stuffed;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr;
  int          m_stuff;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Real bytes still waiting in the hardware buffer (inserted zeros are not buffered).
  function automatic int occ();
    int n = 0;
    foreach (q[i]) if (!q[i].stuffed) n++;
    return n;
  endfunction

  // Called at a falling edge: check, drive inputs for this cycle, advance the model.
  task automatic step(input bit v, input logic [7:0] b, input bit ack,
                      input bit ld, input logic [31:0] la);
    chk("byte_ready", {31'h0, byte_ready_o}, {31'h0, occ() != DEPTH});
    chk("busy", {31'h0, busy_o}, {31'h0, q.size() != 0});
    chk("addr_track", vlx_addr_o, m_addr);
    chk("stuff_cnt", {16'h0, stuff_cnt_o}, m_stuff);
    byte_valid_i    = v;
    byte_i          = b;
    ack_i           = ack;
    set_init_addr_i = ld;
    addr_i          = la;
    if (ack && store_byte_o) begin
      if (q.size() == 0) begin
        chk("store_unexpected", {31'h0, store_byte_o}, 32'h0);
      end else begin
        chk("store_data", dat_o, {4{q[0].d}});
        chk("store_addr", vlx_addr_o, m_addr);
        if (q[0].stuffed && m_stuff < 16'hFFFF) m_stuff++;
        void'(q.pop_front());
        m_addr = m_addr + 32'd1;
      end
    end
    if (ld) m_addr = la;
    if (v && byte_ready_o) begin
      q.push_back('{d: b, stuffed: 1'b0});
      if (EN && b == 8'hFF) q.push_back('{d: 8'h00, stuffed: 1'b1});
    end
    @(negedge clk_i);
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
  endtask

  // Acknowledge each request one cycle after it first appears.
  task automatic drain();
    bit prev = 1'b0;
    bit a;
    int n = 0;
    while ((q.size() != 0 || busy_o) && n < 300) begin
      a    = store_byte_o && prev;
      prev = store_byte_o && !a;
      step(1'b0, 8'h00, a, 1'b0, 32'h0);
      n++;
    end
    chk("drain_done", {31'h0, n < 300}, 32'h1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!store_byte_o && n < 20) begin
      idle_step();
      n++;
    end
    chk("req_seen", {31'h0, store_byte_o}, 32'h1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_valid_i = 1'b0; ack_i = 1'b0; set_init_addr_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    m_addr  = 32'h0;
    m_stuff = 0;
    chk("rst_store", {31'h0, store_byte_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_ready", {31'h0, byte_ready_o}, 32'h1);
    chk("rst_addr", vlx_addr_o, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_stuff", {16'h0, stuff_cnt_o}, 32'h0);
  endtask

  initial begin
    logic [7:0] rb;
    int         n;

    @(negedge clk_i);
    do_reset();

    // Two plain bytes from 0x1000.
    step(1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_1000);
    step(1'b1, 8'h12, 1'b0, 1'b0, 32'h0);
    step(1'b1, 8'h34, 1'b0, 1'b0, 32'h0);
    drain();
    chk("final_addr_1002", vlx_addr_o, 32'h0000_1002);
    chk("busy_fell", {31'h0, busy_o}, 32'h0);

    // 0xFF followed by 0x00: stuffing inserts an extra zero when enabled.
    step(1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_3000);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 32'h0);
    drain();
    chk("stuff_count_one", {16'h0, stuff_cnt_o}, EN ? 32'd1 : 32'd0);
    chk("addr_after_ff", vlx_addr_o, EN ? 32'h0000_3003 : 32'h0000_3002);

    // Back-to-back 0xFF bytes.
    step(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0);
    drain();
    chk("stuff_count_ff_ff", {16'h0, stuff_cnt_o}, EN ? 32'd3 : 32'd0);

    // Fill with ack held low: the 5th byte waits until the first ack.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 32'h0);
    byte_valid_i = 1'b1; byte_i = 8'hA4;
    chk("ready_full", {31'h0, byte_ready_o}, 32'h0);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 32'h0);
    chk("ready_still_full", {31'h0, byte_ready_o}, 32'h0);
    step(1'b1, 8'hA4, 1'b1, 1'b0, 32'h0);
    chk("ready_after_ack", {31'h0, byte_ready_o}, 32'h1);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 32'h0);
    drain();

    // Address load coinciding with an ack: load wins.
    step(1'b1, 8'h55, 1'b0, 1'b0, 32'h0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 32'h0);
    wait_req();
    step(1'b0, 8'h00, 1'b1, 1'b1, 32'h0000_2000);
    chk("load_wins", vlx_addr_o, 32'h0000_2000);
    drain();
    chk("addr_after_load", vlx_addr_o, 32'h0000_2001);

    // Reset with a store in flight and three bytes buffered.
    for (int i = 0; i < 4; i++)
      step(1'b1, (i == 0) ? 8'hFF : 8'(i), 1'b0, 1'b0, 32'h0);
    wait_req();
    step(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
    chk("busy_before_rst", {31'h0, busy_o}, 32'h1);
    do_reset();
    idle_step();
    chk("rst_stays_idle", {31'h0, store_byte_o}, 32'h0);

    // Address wrap at the top of the space.
    step(1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 8'h77, 1'b0, 1'b0, 32'h0);
    drain();
    chk("addr_wrap", vlx_addr_o, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rb = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), $urandom);
    end
    drain();
    n = 0;
    while (n < 5) begin idle_step(); n++; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
